// File: rtl/ppc_types.sv
// Shared types for the PowerPC-style out-of-order core: condition/exception
// update bundle and the common-data-bus entry layout.
package ppc_types;

  // CR0 field plus the XER summary-overflow, overflow and carry bits.
  typedef struct packed {
    logic [3:0] cr0;
    logic       so;
    logic       ov;
    logic       ca;
  } cond_exception_t;

  // Upper bound on the number of execution units sharing one result bus.
  localparam int CDB_MAX_UNITS = 16;

  // Widest reservation-station ID any arbiter instance may carry.
  localparam int CDB_MAX_RS_ID_WIDTH = 5;

  // One result-bus entry; narrower RS IDs are zero-extended into rs_id.
  typedef struct packed {
    logic [CDB_MAX_RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]                     reg_addr;
    logic [31:0]                    result;
    cond_exception_t                cr0_xer;
  } cdb_entry_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: scans the request vector starting
// at ptr_i, wrapping around, and returns the first set request.
module rr_priority_picker #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic found_s;

  // Walk the requests from the priority pointer and latch the first hit.
  always_comb begin
    grant_o = {N{1'b0}};
    idx_o   = {IW{1'b0}};
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(ptr_i) + k) % N;
      if (!found_s && req_i[j]) begin
        found_s    = 1'b1;
        idx_o      = IW'(j);
        grant_o[j] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    any_o = found_s;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus. Grants one execution unit per
// cycle into a one-entry registered output stage feeding the ROB and the
// reservation-station operand-update ports.
module cdb_arbiter
  import ppc_types::*;
#(
  parameter  int NUM_UNITS   = 4,
  parameter  int RS_ID_WIDTH = 5,
  localparam int UW          = $clog2(NUM_UNITS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_UNITS-1:0]               unit_valid,
  output logic [NUM_UNITS-1:0]               unit_ready,
  input  logic [NUM_UNITS*RS_ID_WIDTH-1:0]   unit_rs_id,
  input  logic [NUM_UNITS*5-1:0]             unit_reg_addr,
  input  logic [NUM_UNITS*32-1:0]            unit_result,
  input  cond_exception_t [NUM_UNITS-1:0]    unit_cr0_xer,
  output logic                               cdb_valid,
  input  logic                               cdb_ready,
  output logic [RS_ID_WIDTH-1:0]             cdb_rs_id,
  output logic [4:0]                         cdb_reg_addr,
  output logic [31:0]                        cdb_result,
  output cond_exception_t                    cdb_cr0_xer,
  output logic [UW-1:0]                      cdb_unit
);

  logic [NUM_UNITS-1:0] grant_s;
  logic [UW-1:0]        win_s;
  logic                 any_s;
  logic                 can_load_s;
  logic                 xfer_s;
  cdb_entry_t           win_entry_s;

  logic                 cdb_valid_q, cdb_valid_d;
  cdb_entry_t           entry_q, entry_d;
  logic [UW-1:0]        unit_q, unit_d;
  logic [UW-1:0]        prio_q, prio_d;

  rr_priority_picker #(
    .N (NUM_UNITS)
  ) u_picker (
    .req_i   (unit_valid),
    .ptr_i   (prio_q),
    .grant_o (grant_s),
    .idx_o   (win_s),
    .any_o   (any_s)
  );

  // Handshake: the stage may load when empty or draining this cycle.
  always_comb begin
    can_load_s = ~cdb_valid_q | cdb_ready;
    xfer_s     = any_s & can_load_s & ~rst;
    if (xfer_s) begin
      unit_ready = grant_s;
    end else begin
      unit_ready = {NUM_UNITS{1'b0}};
    end
  end

  // Select the winning unit's payload from the flattened input buses.
  always_comb begin
    win_entry_s.rs_id    = CDB_MAX_RS_ID_WIDTH'(unit_rs_id[int'(win_s)*RS_ID_WIDTH +: RS_ID_WIDTH]);
    win_entry_s.reg_addr = unit_reg_addr[int'(win_s)*5 +: 5];
    win_entry_s.result   = unit_result[int'(win_s)*32 +: 32];
    win_entry_s.cr0_xer  = unit_cr0_xer[win_s];
  end

  // Next state of the output stage and the rotating priority pointer.
  always_comb begin
    cdb_valid_d = cdb_valid_q;
    entry_d     = entry_q;
    unit_d      = unit_q;
    prio_d      = prio_q;
    if (xfer_s) begin
      cdb_valid_d = 1'b1;
      entry_d     = win_entry_s;
      unit_d      = win_s;
      if (win_s == UW'(NUM_UNITS - 1)) begin
        prio_d = {UW{1'b0}};
      end else begin
        prio_d = win_s + UW'(1);
      end
    end else if (cdb_ready) begin
      // Drained with nothing to replace it: payload keeps its last value.
      cdb_valid_d = 1'b0;
    end else begin
      cdb_valid_d = cdb_valid_q;
    end
  end

  // State registers; reset discards any held entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      entry_q     <= '{default: '0};
      unit_q      <= {UW{1'b0}};
      prio_q      <= {UW{1'b0}};
    end else begin
      cdb_valid_q <= cdb_valid_d;
      entry_q     <= entry_d;
      unit_q      <= unit_d;
      prio_q      <= prio_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_rs_id    = entry_q.rs_id[RS_ID_WIDTH-1:0];
  assign cdb_reg_addr = entry_q.reg_addr;
  assign cdb_result   = entry_q.result;
  assign cdb_cr0_xer  = entry_q.cr0_xer;
  assign cdb_unit     = unit_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus pushes the expected
// bus entry for each hand-computed grant; a monitor pops and compares every
// entry the bus hands off.
module tb_cdb_arbiter;
  import ppc_types::*;

  localparam int N  = 4;
  localparam int RW = 5;

  logic                     clk;
  logic                     rst;
  logic [N-1:0]             unit_valid;
  logic [N-1:0]             unit_ready;
  logic [N*RW-1:0]          unit_rs_id;
  logic [N*5-1:0]           unit_reg_addr;
  logic [N*32-1:0]          unit_result;
  cond_exception_t [N-1:0]  unit_cr0_xer;
  logic                     cdb_valid;
  logic                     cdb_ready;
  logic [RW-1:0]            cdb_rs_id;
  logic [4:0]               cdb_reg_addr;
  logic [31:0]              cdb_result;
  cond_exception_t          cdb_cr0_xer;
  logic [1:0]               cdb_unit;

  logic [RW-1:0]   p_rs  [N];
  logic [4:0]      p_ra  [N];
  logic [31:0]     p_res [N];
  cond_exception_t p_cr  [N];

  typedef struct {
    int unsigned     unit;
    logic [RW-1:0]   rs;
    logic [4:0]      ra;
    logic [31:0]     res;
    cond_exception_t cr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.NUM_UNITS(N), .RS_ID_WIDTH(RW)) dut (
    .clk           (clk),
    .rst           (rst),
    .unit_valid    (unit_valid),
    .unit_ready    (unit_ready),
    .unit_rs_id    (unit_rs_id),
    .unit_reg_addr (unit_reg_addr),
    .unit_result   (unit_result),
    .unit_cr0_xer  (unit_cr0_xer),
    .cdb_valid     (cdb_valid),
    .cdb_ready     (cdb_ready),
    .cdb_rs_id     (cdb_rs_id),
    .cdb_reg_addr  (cdb_reg_addr),
    .cdb_result    (cdb_result),
    .cdb_cr0_xer   (cdb_cr0_xer),
    .cdb_unit      (cdb_unit)
  );

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign unit_rs_id[g*RW +: RW]    = p_rs[g];
    assign unit_reg_addr[g*5 +: 5]   = p_ra[g];
    assign unit_result[g*32 +: 32]   = p_res[g];
    assign unit_cr0_xer[g]           = p_cr[g];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_unit(input int u, input logic [RW-1:0] rs, input logic [4:0] ra,
                          input logic [31:0] res, input logic [6:0] cr);
    p_rs[u]  = rs;
    p_ra[u]  = ra;
    p_res[u] = res;
    p_cr[u]  = cond_exception_t'(cr);
  endtask

  task automatic set_all(input int s);
    for (int u = 0; u < N; u++) begin
      set_unit(u, RW'(u * 4 + s), 5'(u + s), {8'(u), 8'(s), 16'hA5A5}, 7'(u + s));
    end
  endtask

  // One cycle of stimulus: drive, check the grant, push expectation, advance.
  task automatic cyc(input logic [N-1:0] v, input logic r, input int w);
    logic [N-1:0] m;
    exp_t e;
    unit_valid = v;
    cdb_ready  = r;
    #1;
    m = (w >= 0) ? N'(1 << w) : {N{1'b0}};
    chk("unit_ready", 64'(unit_ready), 64'(m));
    if (w >= 0) begin
      e.unit = w;
      e.rs   = p_rs[w];
      e.ra   = p_ra[w];
      e.res  = p_res[w];
      e.cr   = p_cr[w];
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handed-off bus entry must match the scoreboard front.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && cdb_valid && cdb_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_entry", 64'(cdb_unit), 64'hFFFF);
      end else begin
        e = q.pop_front();
        chk("cdb_unit",     64'(cdb_unit),     64'(e.unit));
        chk("cdb_rs_id",    64'(cdb_rs_id),    64'(e.rs));
        chk("cdb_reg_addr", 64'(cdb_reg_addr), 64'(e.ra));
        chk("cdb_result",   64'(cdb_result),   64'(e.res));
        chk("cdb_cr0_xer",  64'(cdb_cr0_xer),  64'(e.cr));
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"},  64'(cdb_valid),    64'h0);
    chk({tag, "_rs_id"},  64'(cdb_rs_id),    64'h0);
    chk({tag, "_reg"},    64'(cdb_reg_addr), 64'h0);
    chk({tag, "_result"}, 64'(cdb_result),   64'h0);
    chk({tag, "_cr"},     64'(cdb_cr0_xer),  64'h0);
    chk({tag, "_unit"},   64'(cdb_unit),     64'h0);
    chk({tag, "_prio"},   64'(dut.prio_q),   64'h0);
  endtask

  initial begin
    for (int u = 0; u < N; u++) set_unit(u, 5'd0, 5'd0, 32'd0, 7'd0);
    rst        = 1'b1;
    unit_valid = 4'hF;
    cdb_ready  = 1'b1;

    // Reset: no grants while rst is high, outputs cleared.
    @(posedge clk); #1;
    chk("reset_unit_ready", 64'(unit_ready), 64'h0);
    @(posedge clk); #1;
    chk_zero_outputs("reset");
    rst        = 1'b0;
    unit_valid = 4'h0;

    // Single requester: unit 2.
    set_unit(2, 5'd5, 5'd7, 32'hDEADBEEF, 7'h15);
    cyc(4'b0100, 1'b1, 2);
    chk("single_valid", 64'(cdb_valid),  64'h1);
    chk("single_unit",  64'(cdb_unit),   64'h2);
    chk("single_res",   64'(cdb_result), 64'hDEADBEEF);
    chk("single_rs",    64'(cdb_rs_id),  64'h5);
    chk("single_prio",  64'(dut.prio_q), 64'h3);
    // Drain with no requests: valid falls, pointer unchanged.
    cyc(4'b0000, 1'b1, -1);
    chk("drain_valid", 64'(cdb_valid),  64'h0);
    chk("drain_prio",  64'(dut.prio_q), 64'h3);

    // All four units continuously valid, starting from pointer 3.
    for (int s = 0; s < 8; s++) begin
      set_all(s);
      cyc(4'hF, 1'b1, (3 + s) % 4);
      chk("stream_valid", 64'(cdb_valid), 64'h1);
    end
    chk("stream_prio", 64'(dut.prio_q), 64'h3);

    // Bus stall: unit 1 granted, then three cycles of cdb_ready low.
    set_all(8);
    cyc(4'b0010, 1'b1, 1);
    for (int c = 0; c < 3; c++) begin
      cyc(4'b1001, 1'b0, -1);
      chk("stall_valid", 64'(cdb_valid),  64'h1);
      chk("stall_unit",  64'(cdb_unit),   64'h1);
      chk("stall_res",   64'(cdb_result), 64'h0108A5A5);
      chk("stall_prio",  64'(dut.prio_q), 64'h2);
    end
    cyc(4'b1001, 1'b1, 3);
    cyc(4'b1001, 1'b1, 0);
    chk("after_stall_prio", 64'(dut.prio_q), 64'h1);

    // Back-to-back replace of a valid entry by unit 0.
    set_unit(0, 5'd11, 5'd12, 32'h0B0B0B0B, 7'h2A);
    cyc(4'b0001, 1'b1, 0);
    chk("b2b_valid", 64'(cdb_valid),  64'h1);
    chk("b2b_res",   64'(cdb_result), 64'h0B0B0B0B);

    // Reset while an entry is held.
    cyc(4'b0010, 1'b0, -1);
    cyc(4'b0010, 1'b0, -1);
    rst        = 1'b1;
    unit_valid = 4'b0010;
    #1;
    chk("rst_mid_ready", 64'(unit_ready), 64'h0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero_outputs("rst_mid");
    cyc(4'b1111, 1'b1, 0);
    cyc(4'b1010, 1'b1, 1);

    // No requests after draining: pointer stays put.
    cyc(4'b0000, 1'b1, -1);
    cyc(4'b0000, 1'b1, -1);
    chk("idle_valid",  64'(cdb_valid),  64'h0);
    chk("idle_prio",   64'(dut.prio_q), 64'h2);
    chk("queue_empty", 64'(q.size()),   64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter sharing the single result (common data) bus between the execution-unit wrappers (ALU, MUL, DIV, …). Each unit presents a ready-valid result; the block grants one per cycle, registers it in a one-entry output stage and drives the result bus toward the reorder buffer and the reservation-station operand-update ports. Fairness comes from a rotating priority pointer, so no unit starves while the bus is contended.

## Interface
- NUM_UNITS, 4: number of requesting execution units (≥2).
- RS_ID_WIDTH, 5: width of reservation-station IDs carried with results.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- unit_valid  in  NUM_UNITS  per-unit result valid; bit 0 is unit 0.
- unit_ready  out  NUM_UNITS  per-unit accept; a transfer occurs when valid & ready.
- unit_rs_id  in  NUM_UNITS*RS_ID_WIDTH  per-unit RS ID; unit 0 occupies [0:RS_ID_WIDTH-1].
- unit_reg_addr  in  NUM_UNITS*5  per-unit destination GPR, same slicing.
- unit_result  in  NUM_UNITS*32  per-unit result value, same slicing.
- unit_cr0_xer  in  NUM_UNITS x cond_exception_t  per-unit CR0/XER update.
- cdb_valid  out  1  result bus holds a valid entry.
- cdb_ready  in  1  consumer accepts the bus entry.
- cdb_rs_id  out  RS_ID_WIDTH  RS ID of the bus entry.
- cdb_reg_addr  out  5  destination GPR of the bus entry.
- cdb_result  out  32  result value.
- cdb_cr0_xer  out  cond_exception_t  CR0/XER update.
- cdb_unit  out  $clog2(NUM_UNITS)  index of the unit that produced the entry.

## Operation
- Output stage: one register entry (valid + payload). `can_load = ~cdb_valid | cdb_ready`.
- Arbitration (combinational): scan unit_valid starting at `prio_ptr`, wrapping modulo NUM_UNITS. The first set bit is the winner. The grant depends only on unit_valid and prio_ptr, never on the unit's own ready.
- unit_ready[i] = (i == winner) & any(unit_valid) & can_load. All other bits are 0.
- On a transfer:
  - The winner's payload loads the output register; cdb_unit = winner; cdb_valid = 1.
  - prio_ptr ← (winner + 1) mod NUM_UNITS.
- cdb_ready & cdb_valid with no new winner: cdb_valid ← 0. Payload registers hold their last value.
- cdb_ready & cdb_valid with a winner in the same cycle: the entry is replaced back-to-back. Full throughput is one result per cycle.
- cdb_valid & ~cdb_ready: all unit_ready = 0, the output is held stable, prio_ptr unchanged.
- No requests: prio_ptr unchanged.
- Reset:
  - cdb_valid = 0; cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer, cdb_unit = 0; prio_ptr = 0.
  - unit_ready = 0 during the reset cycle.
  - A reset while an entry is held discards the entry. The unit side keeps its own result.

## Timing
- Latency: unit transfer in cycle N, then cdb_valid and payload visible from cycle N+1.
- unit_ready is combinational from unit_valid, cdb_valid and cdb_ready. There are no combinational paths from unit payload inputs to any output.
- A held entry stays constant until cdb_ready is sampled high (AXI-style stability).
- Worst-case wait for a continuously valid unit: NUM_UNITS-1 grants to other units, provided the bus is not stalled.
- Wrap-around: a winner of NUM_UNITS-1 sets prio_ptr to 0.

## Structure
- cond_exception_t is already in ppc_types and is reused.
- Add `CDB_MAX_UNITS` to ppc_types.
- Add `cdb_entry_t` to ppc_types: packed struct of rs_id, reg_addr, result, cr0_xer. It is parameterised by using the maximum RS_ID_WIDTH, or defined locally if widths differ.
- One natural sub-module: `rr_priority_picker`. It is purely combinational, takes (request vector, prio_ptr) and returns (one-hot grant, winner index, any). It can be reused by other shared-resource arbiters.
- The top module holds prio_ptr, the output register and the handshake logic.

## Test plan
- **Single requester.** Reset, then unit 2 valid with rs_id=5, reg=7, result=0xDEADBEEF; cdb_ready=1.
  - Required: unit_ready[2]=1 in cycle 0.
  - Required: in cycle 1, cdb_valid=1, cdb_unit=2, cdb_result=0xDEADBEEF, cdb_rs_id=5.
  - Required: prio_ptr=3.
- **All four units valid continuously, cdb_ready=1.**
  - Required: grant order 0,1,2,3,0,… with one result per cycle and no gaps.
- **Bus stall.** Unit 1 granted, then cdb_ready=0 for 3 cycles while units 0 and 3 stay valid.
  - Required: payload held unchanged and unit_ready=0 for those 3 cycles.
  - Required: after cdb_ready rises, unit 3 wins next (prio_ptr=2), then unit 0.
- **Back-to-back replace.** cdb_valid=1 and cdb_ready=1 with unit 0 valid.
  - Required: the new entry loads in the same cycle and cdb_valid stays 1.
- **Reset mid-stall.** Entry held with cdb_ready=0, then rst=1 for one cycle.
  - Required: next cycle cdb_valid=0, all payload outputs 0, prio_ptr=0.
  - Required: unit 0 wins first afterwards.
- **No requests.** All unit_valid=0 after an entry drains.
  - Required: cdb_valid falls one cycle after cdb_ready and prio_ptr is unchanged.
